alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The module SHALL have these ports: clk (input, 1 bit), the single clock, rising edge active.
REQ-002 reset (input, 1 bit): asynchronous, active-high reset.
REQ-003 A (input, 8 bits): first operand.
REQ-004 B (input, 8 bits): second operand.
REQ-005 operation (input, 4 bits): operation select.
REQ-006 result (output, 8 bits): combinational operation result.
REQ-007 C (output, 1 bit): registered carry/borrow flag.
REQ-008 Z (output, 1 bit): registered zero flag.
REQ-009 S (output, 1 bit): registered sign flag.

Function
REQ-010 The result output SHALL be combinational from A, B, operation and the current registered C.
REQ-011 The operation encoding SHALL be:
- 0000 ADD: A+B
- 0001 SUB: A-B
- 0010 ADC: A+B+C
- 0011 SBC: A-B-C
- 0100 AND: A&B
- 0101 OR: A|B
- 0110 NOT: ~B
- 0111 XOR: A^B
- 1000 INC: B+1
- 1001 DEC: B-1
- 1010 CMP: A-B
- 1011 TST: A&B
- 1100 SHL: {A[6:0],0}
- 1101 SHR: {0,A[7:1]}
- 1110 ROL: {A[6:0],A[7]}
- 1111 ROR: {A[0],A[7:1]}
REQ-012 Arithmetic SHALL be 8-bit and SHALL wrap modulo 256; there SHALL be no saturation.
REQ-013 The next carry SHALL be:
- ADD, ADC, INC: carry out of bit 7.
- SUB, SBC, DEC, CMP: borrow, i.e. 1 when the unsigned subtrahend (plus carry-in, for SBC) exceeds the minuend.
- AND, OR, NOT, XOR, TST: 0.
- Shift and rotate ops: the bit shifted out (A[7] for 1100/1110, A[0] for 1101/1111).
REQ-014 The next Z SHALL be 1 when the 8-bit result equals 0x00; the next S SHALL be result[7].
REQ-015 CMP and TST SHALL drive result normally; whether the result is written back is decided by the caller.
REQ-016 The block SHALL keep an internal capture record of {operation, A, B} plus a valid bit.
REQ-017 On each rising clk edge, when the valid bit is 0 or {operation, A, B} differs from the record, C/Z/S SHALL load the next flags and the record SHALL update with valid set to 1; otherwise the flags SHALL hold.
REQ-018 Flag update latency SHALL be one edge. At the capturing edge, any consumer sampling result SHALL see the value computed with the pre-edge C.
REQ-019 Repeating an identical {operation, A, B} on consecutive cycles SHALL NOT re-update the flags; this prevents ADC/SBC/RCL/RCR self-oscillation.
REQ-020 The block SHALL contain no other state.

Reset
REQ-021 While reset is high, C, Z, S and the record valid bit SHALL be 0, asynchronously, regardless of clk.
REQ-022 The first edge after reset deasserts SHALL always capture flags.
REQ-023 Reset asserted mid-operation SHALL clear the flags immediately; result SHALL then be recomputed with C=0.

Configuration
REQ-024 Macro ALU_ROTATE_THROUGH_CARRY_EN:
- Defined: 1110 SHALL be RCL {A[6:0],C} and 1111 SHALL be RCR {C,A[7:1]}, with the next C equal to the bit shifted out.
- Undefined: plain ROL/ROR as in REQ-011.
- All other operations SHALL be identical in both builds.

Verification
REQ-025 ADD, A=0xFF, B=0x01 -> result 0x00; after the edge C=1, Z=1, S=0.
REQ-026 SUB, A=0x10, B=0x20 -> result 0xF0; after the edge C=1, Z=0, S=1. CMP, A=0x05, B=0x05 -> Z=1, C=0.
REQ-027 Set C=1 first (ADD 0xFF+0x01), then ADC, A=0x01, B=0x01 -> result 0x03 before the edge; after the edge C=0, and result becomes 0x02 while the inputs are held with no further flag update.
REQ-028 SHR, A=0x81 -> 0x40, C=1. ROR, A=0x01 -> 0x80 when the macro is undefined. With the macro defined, RCR, A=0x01, C=0 -> 0x00, Z=1, C=1.
REQ-029 INC, B=0xFF -> 0x00, C=1, Z=1. DEC, B=0x00 -> 0xFF, C=1, S=1. NOT, B=0x0F -> 0xF0, C=0.
REQ-030 With flags nonzero, assert reset between clock edges -> C=Z=S=0 immediately. Deassert, then apply any operation -> the first edge captures its flags.

Source files
------------

// File: rtl/alu.sv
// 8-bit ALU with combinational result and registered C/Z/S flags captured once per distinct {operation, A, B}.
// Define ALU_ROTATE_THROUGH_CARRY_EN to turn ops 1110/1111 into RCL/RCR through C instead of ROL/ROR.
module alu (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] operation,
  output logic [7:0] result,
  output logic       C,
  output logic       Z,
  output logic       S
);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_ADC = 4'h2, OP_SBC = 4'h3,
    OP_AND = 4'h4, OP_OR  = 4'h5, OP_NOT = 4'h6, OP_XOR = 4'h7,
    OP_INC = 4'h8, OP_DEC = 4'h9, OP_CMP = 4'hA, OP_TST = 4'hB,
    OP_SHL = 4'hC, OP_SHR = 4'hD, OP_ROL = 4'hE, OP_ROR = 4'hF
  } op_t;

  op_t        op;
  logic [8:0] wide;
  logic [8:0] carry_in;
  logic       next_c;
  logic       capture;
  logic [3:0] rec_op;
  logic [7:0] rec_a;
  logic [7:0] rec_b;
  logic       rec_valid;

  assign op       = op_t'(operation);
  assign carry_in = {8'd0, C};

  // Arithmetic runs 9 bits wide so bit 8 is the carry out or, for subtraction, the borrow.
  always_comb begin
    wide   = 9'd0;
    result = 8'h00;
    next_c = 1'b0;
    case (op)
      OP_ADD: wide = {1'b0, A} + {1'b0, B};
      OP_SUB: wide = {1'b0, A} - {1'b0, B};
      OP_ADC: wide = {1'b0, A} + {1'b0, B} + carry_in;
      OP_SBC: wide = {1'b0, A} - {1'b0, B} - carry_in;
      OP_INC: wide = {1'b0, B} + 9'd1;
      OP_DEC: wide = {1'b0, B} - 9'd1;
      OP_CMP: wide = {1'b0, A} - {1'b0, B};
      OP_AND: wide = {1'b0, A & B};
      OP_OR:  wide = {1'b0, A | B};
      OP_NOT: wide = {1'b0, ~B};
      OP_XOR: wide = {1'b0, A ^ B};
      OP_TST: wide = {1'b0, A & B};
      OP_SHL: wide = {A[7], A[6:0], 1'b0};
      OP_SHR: wide = {A[0], 1'b0, A[7:1]};
`ifdef ALU_ROTATE_THROUGH_CARRY_EN
      OP_ROL: wide = {A[7], A[6:0], C};
      OP_ROR: wide = {A[0], C, A[7:1]};
`else
      OP_ROL: wide = {A[7], A[6:0], A[7]};
      OP_ROR: wide = {A[0], A[0], A[7:1]};
`endif
      default: wide = 9'd0;
    endcase
    result = wide[7:0];
    next_c = wide[8];
  end

  // Re-capturing an unchanged command would let ADC/SBC/RCL/RCR feed their own carry back.
  assign capture = !rec_valid || ({operation, A, B} != {rec_op, rec_a, rec_b});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      C         <= 1'b0;
      Z         <= 1'b0;
      S         <= 1'b0;
      rec_valid <= 1'b0;
      rec_op    <= 4'h0;
      rec_a     <= 8'h00;
      rec_b     <= 8'h00;
    end else if (capture) begin
      C         <= next_c;
      Z         <= (result == 8'h00);
      S         <= result[7];
      rec_valid <= 1'b1;
      rec_op    <= operation;
      rec_a     <= A;
      rec_b     <= B;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: vector table plus a flag scoreboard, then hand-written hold and reset sequences.
module tb_alu;

  logic       clk;
  logic       reset;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] operation;
  logic [7:0] result;
  logic       C;
  logic       Z;
  logic       S;

  int vectors_applied;
  int miscompares;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       s;
  } vec_t;

  typedef struct packed {
    logic c;
    logic z;
    logic s;
  } flags_t;

  vec_t   vecs[$];
  flags_t sb_q[$];

  alu dut (
    .clk(clk),
    .reset(reset),
    .A(A),
    .B(B),
    .operation(operation),
    .result(result),
    .C(C),
    .Z(Z),
    .S(S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input logic c, input logic z, input logic s);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.c = c; v.z = z; v.s = s;
    vecs.push_back(v);
  endtask

  // Drive at the falling edge, check the combinational result, and queue the flags expected after the next rise.
  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] res,
                               input logic c, input logic z, input logic s);
    flags_t f;
    @(negedge clk);
    operation = op;
    A = a;
    B = b;
    #1;
    check({name, " result"}, result, res);
    f.c = c; f.z = z; f.s = s;
    sb_q.push_back(f);
  endtask

  task automatic checkOutput(input string name);
    flags_t f;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      vectors_applied++;
      miscompares++;
      $display("[TB] FAIL %s scoreboard: got empty queue expected entry", name);
    end else begin
      f = sb_q.pop_front();
      check({name, " C"}, {7'd0, C}, {7'd0, f.c});
      check({name, " Z"}, {7'd0, Z}, {7'd0, f.z});
      check({name, " S"}, {7'd0, S}, {7'd0, f.s});
    end
  endtask

  task automatic check_flags(input string name, input logic c, input logic z, input logic s);
    check({name, " C"}, {7'd0, C}, {7'd0, c});
    check({name, " Z"}, {7'd0, Z}, {7'd0, z});
    check({name, " S"}, {7'd0, S}, {7'd0, s});
  endtask

  initial begin
    vectors_applied = 0;
    miscompares = 0;
    reset = 1'b1;
    operation = 4'h0;
    A = 8'h00;
    B = 8'h00;

    // Expected values assume the C left behind by the previous row.
    add_vec(4'h0, 8'hFF, 8'h01, 8'h00, 1, 1, 0);
    add_vec(4'h2, 8'h01, 8'h01, 8'h03, 0, 0, 0);
    add_vec(4'h1, 8'h10, 8'h20, 8'hF0, 1, 0, 1);
    add_vec(4'h3, 8'h10, 8'h05, 8'h0A, 0, 0, 0);
    add_vec(4'h3, 8'h05, 8'h05, 8'h00, 0, 1, 0);
    add_vec(4'hA, 8'h05, 8'h05, 8'h00, 0, 1, 0);
    add_vec(4'h4, 8'hF0, 8'h3C, 8'h30, 0, 0, 0);
    add_vec(4'h5, 8'h80, 8'h01, 8'h81, 0, 0, 1);
    add_vec(4'h6, 8'h55, 8'h0F, 8'hF0, 0, 0, 1);
    add_vec(4'h7, 8'hAA, 8'hFF, 8'h55, 0, 0, 0);
    add_vec(4'h8, 8'h00, 8'hFF, 8'h00, 1, 1, 0);
    add_vec(4'h9, 8'h00, 8'h00, 8'hFF, 1, 0, 1);
    add_vec(4'hB, 8'h0F, 8'hF0, 8'h00, 0, 1, 0);
    add_vec(4'hC, 8'h81, 8'h00, 8'h02, 1, 0, 0);
    add_vec(4'hD, 8'h81, 8'h00, 8'h40, 1, 0, 0);
`ifdef ALU_ROTATE_THROUGH_CARRY_EN
    add_vec(4'hE, 8'h40, 8'h00, 8'h81, 0, 0, 1);
    add_vec(4'hF, 8'h01, 8'h00, 8'h00, 1, 1, 0);
`else
    add_vec(4'hE, 8'h40, 8'h00, 8'h80, 0, 0, 1);
    add_vec(4'hF, 8'h01, 8'h00, 8'h80, 1, 0, 1);
`endif
    add_vec(4'h2, 8'h7F, 8'h80, 8'h00, 1, 1, 0);
    add_vec(4'h3, 8'h00, 8'h00, 8'hFF, 1, 0, 1);
    add_vec(4'h9, 8'h00, 8'h01, 8'h00, 0, 1, 0);
    add_vec(4'h8, 8'h00, 8'h7F, 8'h80, 0, 0, 1);
    add_vec(4'h1, 8'h20, 8'h10, 8'h10, 0, 0, 0);

    #1;
    check_flags("reset async", 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_flags("reset held", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].s);
      checkOutput($sformatf("vec%0d", i));
    end

    // ADC with C=1 then held: result drops to 0x02 and the flags must not re-capture.
    applyStimulus("setc", 4'h0, 8'hFF, 8'h01, 8'h00, 1, 1, 0);
    checkOutput("setc");
    applyStimulus("adc_hold", 4'h2, 8'h01, 8'h01, 8'h03, 0, 0, 0);
    checkOutput("adc_hold");
    check("adc_hold after", result, 8'h02);

    // ADC 0x7F+0x00 with C=1 gives 0x80 (S=1); a re-capture would see 0x7F and clear S.
    applyStimulus("setc2", 4'h0, 8'hFF, 8'h01, 8'h00, 1, 1, 0);
    checkOutput("setc2");
    applyStimulus("adc_s", 4'h2, 8'h7F, 8'h00, 8'h80, 0, 0, 1);
    checkOutput("adc_s");
    check("adc_s after", result, 8'h7F);
    repeat (3) @(posedge clk);
    #1;
    check_flags("adc_s held", 0, 0, 1);
    check("adc_s held result", result, 8'h7F);

    // Reset between edges clears flags at once and result follows C=0.
    applyStimulus("setc3", 4'h0, 8'hFF, 8'h01, 8'h00, 1, 1, 0);
    checkOutput("setc3");
    @(negedge clk);
    operation = 4'h2; A = 8'h01; B = 8'h01;
    #1;
    check("rst adc pre", result, 8'h03);
    reset = 1'b1;
    #1;
    check_flags("rst mid", 0, 0, 0);
    check("rst adc post", result, 8'h02);
    reset = 1'b0;

    // Same command as the record before reset must still capture on the first edge.
    applyStimulus("rst_first0", 4'h0, 8'hFF, 8'h01, 8'h00, 1, 1, 0);
    checkOutput("rst_first0");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_flags("rst mid2", 0, 0, 0);
    reset = 1'b0;
    sb_q.push_back(flags_t'{c: 1'b1, z: 1'b1, s: 1'b0});
    checkOutput("rst_first1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
